// File: rtl/energy_seq_pkg.sv
// +----------------------------------------------------------------------+
// | energy_seq_pkg : shared widths, defaults and FSM state encoding       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package energy_seq_pkg;

  localparam int ACC_W       = 39;
  localparam int MUL_W       = 31;
  localparam int SUB_LEN_DEF = 40;
  localparam int NUM_SUB_DEF = 2;
  localparam int CNT_W       = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACCUM   = 3'd1,
    ST_COMBINE = 3'd2,
    ST_SAVE    = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/energy_seq_counter.sv
// +----------------------------------------------------------------------+
// | subframe_counter : sample counter with terminal-count detection       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module subframe_counter
  import energy_seq_pkg::*;
#(
  parameter int SUB_LEN = SUB_LEN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic at_zero,
  output logic terminal
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign at_zero  = (count_q == '0);
  assign terminal = inc && (count_q == CNT_W'(SUB_LEN - 1));

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (terminal) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/energy_seq.sv
// +----------------------------------------------------------------------+
// | energy_seq : half-frame energy sequencer driving an external          |
// |              accumulator across NUM_SUB subframes of SUB_LEN samples  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module energy_seq
  import energy_seq_pkg::*;
#(
  parameter int SUB_LEN = SUB_LEN_DEF,
  parameter int NUM_SUB = NUM_SUB_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             sq_valid,
  output logic             sq_ready,
  input  logic [ACC_W-1:0] sumout,
  output logic             acc_en,
  output logic             acc_new1,
  output logic             acc_sel,
  output logic [ACC_W-1:0] ereg,
  output logic [ACC_W-1:0] frame_energy,
  output logic [1:0]       sub_idx,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [1:0]       sub_idx_q, sub_idx_d;
  logic [ACC_W-1:0] ereg_q, ereg_d;
  logic [ACC_W-1:0] fe_q, fe_d;
  logic             cnt_clr, cnt_inc, cnt_zero, cnt_term;

  subframe_counter #(.SUB_LEN(SUB_LEN)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .at_zero  (cnt_zero),
    .terminal (cnt_term)
  );

  always_comb begin
    state_d   = state_q;
    sub_idx_d = sub_idx_q;
    ereg_d    = ereg_q;
    fe_d      = fe_q;
    sq_ready  = 1'b0;
    acc_en    = 1'b0;
    acc_new1  = 1'b0;
    acc_sel   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_clr   = 1'b1;
        sub_idx_d = 2'd0;
        if (start && !abort) state_d = ST_ACCUM;
      end
      ST_ACCUM: begin
        sq_ready = 1'b1;
        acc_en   = sq_valid;
        acc_new1 = sq_valid && cnt_zero;
        cnt_inc  = sq_valid;
        // The first subframe has nothing to merge, so it skips COMBINE.
        if (cnt_term) state_d = (sub_idx_q == 2'd0) ? ST_SAVE : ST_COMBINE;
      end
      ST_COMBINE: begin
        acc_en  = 1'b1;
        acc_sel = 1'b1;
        state_d = ST_SAVE;
      end
      ST_SAVE: begin
        ereg_d = sumout;
        if (sub_idx_q < 2'(NUM_SUB - 1)) begin
          sub_idx_d = sub_idx_q + 2'd1;
          state_d   = ST_ACCUM;
        end else begin
          fe_d    = sumout;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        sub_idx_d = 2'd0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d   = ST_IDLE;
      sub_idx_d = 2'd0;
      cnt_clr   = 1'b1;
      ereg_d    = ereg_q;
      fe_d      = fe_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sub_idx_q <= 2'd0;
      ereg_q    <= '0;
      fe_q      <= '0;
    end else begin
      state_q   <= state_d;
      sub_idx_q <= sub_idx_d;
      ereg_q    <= ereg_d;
      fe_q      <= fe_d;
    end
  end

  assign ereg         = ereg_q;
  assign frame_energy = fe_q;
  assign sub_idx      = sub_idx_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_energy_seq.sv
// +----------------------------------------------------------------------+
// | tb_energy_seq : randomized scoreboard bench for energy_seq            |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_energy_seq;

  localparam int NSAMP     = 80;
  localparam int SUBL      = 40;
  localparam int M_NORM    = 0;
  localparam int M_RESTART = 1;
  localparam int M_ABORT   = 2;
  localparam int M_RESET   = 3;

  typedef struct {
    logic [38:0] energy;
    logic [38:0] first;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        sq_valid = 1'b0;
  logic        sq_ready;
  logic [38:0] sumout = '0;
  logic [30:0] mul_in = '0;
  logic        acc_en, acc_new1, acc_sel, busy, done;
  logic [38:0] ereg, frame_energy;
  logic [1:0]  sub_idx;

  int   n_pass = 0;
  int   n_total = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  energy_seq dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .sq_valid     (sq_valid),
    .sq_ready     (sq_ready),
    .sumout       (sumout),
    .acc_en       (acc_en),
    .acc_new1     (acc_new1),
    .acc_sel      (acc_sel),
    .ereg         (ereg),
    .frame_energy (frame_energy),
    .sub_idx      (sub_idx),
    .busy         (busy),
    .done         (done)
  );

  // Behavioural 39-bit wrapping accumulator.
  always @(posedge clk) begin
    if (acc_en) begin
      if (acc_new1) sumout <= {8'd0, mul_in};
      else          sumout <= sumout + (acc_sel ? ereg : {8'd0, mul_in});
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  int ncyc = 0;
  int last_acc = 0;
  int new1_cnt = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      ncyc++;
      if (sq_valid && sq_ready) last_acc = ncyc;
      if (acc_en && acc_new1) begin
        new1_cnt++;
        if (new1_cnt == 2 && q.size() > 0) check("ereg_first_save", ereg, q[0].first);
      end
      if (done) begin
        check("done_expected", (q.size() > 0) ? 1 : 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("frame_energy", frame_energy, e.energy);
          check("ereg_final", ereg, e.energy);
          check("done_latency", ncyc - last_acc, 3);
          check("acc_new1_count", new1_cnt, 2);
        end
      end
      if (!busy) new1_cnt = 0;
    end
  end

  task automatic run_frame(input int pat, input int pct, input int mode, input int ev);
    logic [30:0] s[NSAMP];
    logic [38:0] tot, first;
    exp_t        e;
    int          i, cyc;
    logic        hit, acc;
    tot = '0;
    first = '0;
    for (int k = 0; k < NSAMP; k++) begin
      case (pat)
        0:       s[k] = 31'd1;
        1:       s[k] = 31'h7FFFFFFF;
        2:       s[k] = 31'(k + 1);
        3:       s[k] = 31'd2;
        default: s[k] = 31'($urandom);
      endcase
      tot = tot + {8'd0, s[k]};
      if (k < SUBL) first = first + {8'd0, s[k]};
    end
    if (mode == M_NORM || mode == M_RESTART) begin
      e.energy = tot;
      e.first  = first;
      q.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    i = 0;
    cyc = 0;
    hit = 1'b0;
    while (i < NSAMP && cyc < 2000) begin
      sq_valid = ($urandom_range(99) < pct);
      mul_in   = s[i];
      start    = (mode == M_RESTART && i == ev);
      if (mode == M_ABORT && i == ev) begin abort = 1'b1; sq_valid = 1'b0; end
      if (mode == M_RESET && i == ev) begin reset = 1'b1; sq_valid = 1'b0; end
      hit = abort | reset;
      acc = sq_valid && sq_ready;
      @(posedge clk); #1;
      start = 1'b0;
      sq_valid = 1'b0;
      if (hit) begin
        abort = 1'b0;
        reset = 1'b0;
        break;
      end
      if (acc) i++;
      cyc++;
    end
    check("stimulus_budget", (cyc < 2000) ? 1 : 0, 1);
    if (mode == M_ABORT) begin
      check("abort_busy", busy, 0);
      check("abort_sq_ready", sq_ready, 0);
      check("abort_sub_idx", sub_idx, 0);
    end
    if (mode == M_RESET) begin
      check("reset_busy", busy, 0);
      check("reset_ereg", ereg, 0);
      check("reset_frame_energy", frame_energy, 0);
      check("reset_sub_idx", sub_idx, 0);
    end
    for (int w = 0; w < 20 && q.size() > 0; w++) @(posedge clk);
    #1;
    check("scoreboard_drained", q.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ereg", ereg, 0);
    check("rst_frame_energy", frame_energy, 0);
    check("rst_sq_ready", sq_ready, 0);
    check("rst_acc_en", acc_en, 0);

    run_frame(0, 100, M_NORM, 0);
    run_frame(1, 100, M_NORM, 0);
    run_frame(2, 50, M_NORM, 0);
    run_frame(4, 70, M_RESTART, 10);
    run_frame(0, 100, M_ABORT, 50);
    run_frame(3, 100, M_NORM, 0);
    run_frame(2, 80, M_RESET, 30);
    run_frame(4, 60, M_NORM, 0);

    repeat (10) @(posedge clk);
    #1;
    check("final_idle", busy, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/energy_seq.md
ENERGY_SEQ -- requirements
Module: energy_seq

Interface
REQ-001 SHALL have parameter SUB_LEN, default 40, samples per subframe (2..255).
REQ-002 SHALL have parameter NUM_SUB, default 2, subframes per half-frame (1..4).
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begin a half-frame
- abort  in  1  synchronous abandon; return to IDLE
- sq_valid  in  1  square block has a 31-bit sample on mul_in
- sq_ready  out  1  controller accepts a sample this cycle
- sumout  in  39  accumulator result
- acc_en  out  1  accumulator enable
- acc_new1  out  1  accumulator load (start of subframe)
- acc_sel  out  1  0 = add mul_in, 1 = add ereg
- ereg  out  39  running half-frame total fed to the accumulator
- frame_energy  out  39  final half-frame energy
- sub_idx  out  2  current subframe index
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse; frame_energy valid

Function
REQ-005 State machine SHALL use states IDLE, ACCUM, COMBINE, SAVE, DONE.
REQ-006 IDLE: start=1 and abort=0 -> ACCUM; sample counter = 0; sub_idx = 0.
REQ-007 sq_ready SHALL be 1 only in ACCUM; accept = sq_valid & sq_ready.
REQ-008 acc_en SHALL be combinational: accept in ACCUM, or 1 in COMBINE; 0 elsewhere.
REQ-009 acc_new1 SHALL be 1 only on the accept with counter = 0.
REQ-010 acc_sel SHALL be 1 only in COMBINE.
REQ-011 Counter SHALL increment on each accept. Cycles with sq_valid=0 SHALL stall without side effects.
REQ-012 On accept with counter = SUB_LEN-1: counter -> 0, then next state = SAVE if sub_idx = 0, else COMBINE.
REQ-013 COMBINE SHALL last one cycle (sumout <= sumout + ereg), then go to SAVE.
REQ-014 SAVE SHALL last one cycle and capture ereg <= sumout.
- If sub_idx < NUM_SUB-1: increment sub_idx, go to ACCUM.
- Else: frame_energy <= sumout, go to DONE.
REQ-015 DONE SHALL assert done for exactly one cycle, then go to IDLE; frame_energy SHALL hold until the next DONE.
REQ-016 Latency: last accept of the final subframe at cycle t gives done=1 at t+3 when NUM_SUB>1, and at t+2 when NUM_SUB=1.
REQ-017 start SHALL be ignored outside IDLE.
REQ-018 abort SHALL force IDLE next cycle from any state, with all outputs at 0, except that ereg and frame_energy hold their values.
REQ-019 abort SHALL win over start when both occur in the same cycle.
REQ-020 Addition SHALL wrap modulo 2^39 in the accumulator; the controller SHALL NOT saturate or flag overflow.

Reset
REQ-021 reset SHALL dominate abort and start.
REQ-022 reset=1 SHALL clear, at the next edge: state -> IDLE; counter, sub_idx, ereg, frame_energy -> 0; busy, done -> 0. Combinational outputs SHALL be 0 while in IDLE.
REQ-023 reset mid-half-frame SHALL discard partial results; no done pulse SHALL follow.

Structure
REQ-024 A shared package SHALL hold the state enum, ACC_W=39, MUL_W=31, and the default SUB_LEN and NUM_SUB.
REQ-025 A single sub-module, subframe_counter (counter with terminal-count output), is natural; the FSM and registers SHALL stay in energy_seq.

Verification
REQ-026 Bench SHALL pair energy_seq with a behavioural 39-bit accumulator model and cover:
- Defaults, 80 samples of 1, sq_valid held high -> frame_energy = 80; done exactly 3 cycles after the 80th accept; ereg = 40 after the first SAVE.
- 80 samples of 0x7FFFFFFF -> frame_energy = 0x27FFFFFFB0.
- sq_valid randomly low 50% of cycles, samples 1..80 -> frame_energy = 3240; acc_new1 seen exactly twice.
- start pulsed again at sample 10 -> ignored; a single done pulse.
- abort at sample 50 -> IDLE next cycle, no done. A new start with 80x2 -> frame_energy = 160.
- reset at sample 30 -> all registers 0, busy = 0, no done pulse.
